// File: rtl/operand_fetch_pkg.sv
// Shared processor definitions: datapath widths, register-file geometry and
// the 3-bit ALU function codes carried through the operand-fetch stage.
package operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int AW     = 3;
    localparam int ALU_W  = 3;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

endpackage

// File: rtl/reg_file_8x16.sv
// General-purpose register file: one write port, two read ports with
// write-to-read bypass so a value written this cycle is seen by a capture
// on the same edge. Register 0 is hardwired to zero.
module reg_file_8x16
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int NREG   = operand_fetch_pkg::NREG,
    parameter int AW     = operand_fetch_pkg::AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [AW-1:0]     rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o
);

    logic [DATA_W-1:0] rf_q [NREG];

    // Bypassed read: r0 is always zero, a same-cycle write wins over storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     addr,
        input logic              we,
        input logic [AW-1:0]     waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (addr == '0) begin
            return '0;
        end
        if (we && (waddr == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    // Write port; entry 0 is never written so it keeps its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            rf_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Two independent bypassed read ports.
    always_comb begin
        ra_data_o = read_port(ra_addr_i, wr_en_i, wr_addr_i, wr_data_i, rf_q[ra_addr_i]);
        rb_data_o = read_port(rb_addr_i, wr_en_i, wr_addr_i, wr_data_i, rf_q[rb_addr_i]);
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads ALU sources from the register file (with
// writeback bypass), selects the immediate for b when requested, and holds
// the result in a single valid/ready output register for the ALU.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int NREG   = operand_fetch_pkg::NREG,
    parameter int AW     = operand_fetch_pkg::AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [ALU_W-1:0]  alu_control_in,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [ALU_W-1:0]  alu_control_out
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ALU_W-1:0]  ctl_q, ctl_d;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic              capture;

    reg_file_8x16 #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .ra_addr_i (rs_addr),
        .ra_data_o (rs_data),
        .rb_addr_i (rt_addr),
        .rb_data_o (rt_data)
    );

    // Accept when the output slot is free or being drained, unless flushing.
    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign capture  = in_valid && in_ready;

    // Next state: flush empties the slot, capture refills it, a drain empties
    // it; operands only change on capture so a stalled beat stays frozen.
    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        ctl_d       = ctl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            a_d         = rs_data;
            b_d         = use_imm ? imm : rt_data;
            ctl_d       = alu_control_in;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output pipeline register; reset clears both control and operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign a               = a_q;
    assign b               = b_q;
    assign alu_control_out = ctl_q;

endmodule
